// File: rtl/mac_rx_frame_parser.sv
// Ethernet RX frame parser: strips the 14-byte header, filters on destination MAC,
// forwards payload with first/last/error flags. Optional MAC_RX_PROMISC_EN adds promisc_in.
module mac_rx_frame_parser #(
   parameter int MAX_PAYLOAD_LEN = 1500,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 logic_clk,
   input  logic                 logic_rst,
   input  logic [47:0]          local_mac_in,
`ifdef MAC_RX_PROMISC_EN
   input  logic                 promisc_in,
`endif
   input  logic [7:0]           mac_rdata_in,
   input  logic                 mac_rvalid_in,
   output logic                 mac_rready_out,
   input  logic                 mac_rlast_in,
   output logic [7:0]           pld_data_out,
   output logic                 pld_valid_out,
   input  logic                 pld_ready_in,
   output logic                 pld_first_out,
   output logic                 pld_last_out,
   output logic                 pld_err_out,
   output logic [47:0]          hdr_dst_mac_out,
   output logic [47:0]          hdr_src_mac_out,
   output logic [15:0]          hdr_type_out,
   output logic [CNT_WIDTH-1:0] good_frame_cnt_out,
   output logic [CNT_WIDTH-1:0] drop_frame_cnt_out
);

   localparam int PCNT_W = (MAX_PAYLOAD_LEN < 2) ? 1 : $clog2(MAX_PAYLOAD_LEN + 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(MAX_PAYLOAD_LEN - 1);

   typedef enum logic [1:0] {
      S_HDR,
      S_PAYLOAD,
      S_DROP
   } state_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   state_t              state_q, state_d;
   logic [3:0]          hdr_cnt_q, hdr_cnt_d;
   logic [PCNT_W-1:0]   pld_cnt_q, pld_cnt_d;
   logic [103:0]        hdr_stage_p0;
   logic                beat_acc;
   logic                dst_match;
   logic                promisc;
   logic                ld_pld, ld_first, ld_last, ld_err;
   logic                latch_hdr, good_inc, drop_inc;

`ifdef MAC_RX_PROMISC_EN
   assign promisc = promisc_in;
`else
   assign promisc = 1'b0;
`endif

   // Bytes 0..12 are staged; dst occupies the oldest six of them.
   assign dst_match = (hdr_stage_p0[103:56] == local_mac_in) ||
                      (&hdr_stage_p0[103:56]) || promisc;

   always_comb begin
      mac_rready_out = 1'b1;
      case (state_q)
         S_HDR:     mac_rready_out = (hdr_cnt_q == 4'd13) ? !pld_valid_out : 1'b1;
         S_PAYLOAD: mac_rready_out = !pld_valid_out || pld_ready_in;
         default:   mac_rready_out = 1'b1;
      endcase
   end

   assign beat_acc = mac_rvalid_in && mac_rready_out;

   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      pld_cnt_d = pld_cnt_q;
      ld_pld    = 1'b0;
      ld_first  = 1'b0;
      ld_last   = 1'b0;
      ld_err    = 1'b0;
      latch_hdr = 1'b0;
      good_inc  = 1'b0;
      drop_inc  = 1'b0;
      case (state_q)
         S_HDR: begin
            if (beat_acc) begin
               if (mac_rlast_in) begin
                  drop_inc  = 1'b1;
                  hdr_cnt_d = 4'd0;
               end else if (hdr_cnt_q == 4'd13) begin
                  hdr_cnt_d = 4'd0;
                  if (dst_match) begin
                     latch_hdr = 1'b1;
                     pld_cnt_d = '0;
                     state_d   = S_PAYLOAD;
                  end else begin
                     drop_inc = 1'b1;
                     state_d  = S_DROP;
                  end
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 4'd1;
               end
            end
         end
         S_PAYLOAD: begin
            if (beat_acc) begin
               ld_pld    = 1'b1;
               ld_first  = (pld_cnt_q == '0);
               pld_cnt_d = pld_cnt_q + PCNT_W'(1);
               if (mac_rlast_in) begin
                  ld_last  = 1'b1;
                  good_inc = 1'b1;
                  state_d  = S_HDR;
               end else if (pld_cnt_q == PCNT_LAST) begin
                  ld_last  = 1'b1;
                  ld_err   = 1'b1;
                  drop_inc = 1'b1;
                  state_d  = S_DROP;
               end
            end
         end
         S_DROP: begin
            if (beat_acc && mac_rlast_in) begin
               state_d = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase
   end

   always_ff @(posedge logic_clk) begin
      if (logic_rst) begin
         state_q   <= S_HDR;
         hdr_cnt_q <= 4'd0;
         pld_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         pld_cnt_q <= pld_cnt_d;
      end
   end

   // Header staging: plain shift register, refilled by every frame's first 13 bytes.
   always_ff @(posedge logic_clk) begin
      if (beat_acc && (state_q == S_HDR)) begin
         hdr_stage_p0 <= {hdr_stage_p0[95:0], mac_rdata_in};
      end
   end

   // Payload output register stage.
   always_ff @(posedge logic_clk) begin
      if (logic_rst) begin
         pld_valid_out <= 1'b0;
         pld_data_out  <= 8'd0;
         pld_first_out <= 1'b0;
         pld_last_out  <= 1'b0;
         pld_err_out   <= 1'b0;
      end else if (ld_pld) begin
         pld_valid_out <= 1'b1;
         pld_data_out  <= mac_rdata_in;
         pld_first_out <= ld_first;
         pld_last_out  <= ld_last;
         pld_err_out   <= ld_err;
      end else if (pld_ready_in) begin
         pld_valid_out <= 1'b0;
      end
   end

   always_ff @(posedge logic_clk) begin
      if (logic_rst) begin
         hdr_dst_mac_out    <= 48'd0;
         hdr_src_mac_out    <= 48'd0;
         hdr_type_out       <= 16'd0;
         good_frame_cnt_out <= '0;
         drop_frame_cnt_out <= '0;
      end else begin
         if (latch_hdr) begin
            hdr_dst_mac_out <= hdr_stage_p0[103:56];
            hdr_src_mac_out <= hdr_stage_p0[55:8];
            hdr_type_out    <= {hdr_stage_p0[7:0], mac_rdata_in};
         end
         if (good_inc) begin
            good_frame_cnt_out <= sat_inc(good_frame_cnt_out);
         end
         if (drop_inc) begin
            drop_frame_cnt_out <= sat_inc(drop_frame_cnt_out);
         end
      end
   end

endmodule
